// File: rtl/synth_pkg.sv
// Shared constants and helpers for the synth voice datapath.
package synth_pkg;

  localparam int unsigned SYNTH_WAVE_BITS = 8;

  localparam logic [15:0] SYNTH_LFSR_SEED = 16'hACE1;
  // Galois feedback mask for taps 16, 14, 13, 11
  localparam logic [15:0] SYNTH_LFSR_TAPS = 16'hB400;

  function automatic int unsigned midscale(input int unsigned n);
    return 32'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/synth_lfsr16.sv
// 16-bit Galois LFSR; advances by one state on each cycle with step high.
module synth_lfsr16
  import synth_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= SYNTH_LFSR_SEED;
    end else if (step) begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? SYNTH_LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/synth_pwm_dac.sv
// PWM output stage with first-order noise shaping and a one-entry sample buffer.
// Optional frame dither enabled by defining SYNTH_PWM_DITHER_EN.
module synth_pwm_dac
  import synth_pkg::*;
#(
  parameter int WAVE_BITS = SYNTH_WAVE_BITS,
  parameter int PWM_BITS  = 5,
  parameter int SIGNED_IN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WAVE_BITS-1:0] sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 pwm_out,
  output logic                 frame_start,
  output logic                 overrun
);

  localparam int Q = WAVE_BITS - PWM_BITS;
  localparam logic [PWM_BITS:0] FRAME_LEN = (PWM_BITS+1)'(1) << PWM_BITS;

  logic [PWM_BITS-1:0]  cnt;
  logic [PWM_BITS:0]    duty, duty_next;
  logic [Q-1:0]         err, err_next;
  logic [WAVE_BITS-1:0] sample_buf, held, x, conv, sign_flip;
  logic                 pending, boundary;

  assign sample_ready = !pending;
  assign boundary     = (cnt == '1);
  assign sign_flip    = (SIGNED_IN != 0) ? (WAVE_BITS'(1) << (WAVE_BITS - 1)) : '0;
  assign conv         = sample_in ^ sign_flip;
  assign x            = pending ? sample_buf : held;

`ifdef SYNTH_PWM_DITHER_EN
  logic [15:0]          lfsr_value;
  logic [WAVE_BITS+1:0] sum;
  logic [PWM_BITS+1:0]  sum_hi;

  synth_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (boundary),
    .value (lfsr_value)
  );

  // Dither can push the total past full scale; clamp and drop the residue.
  always_comb begin
    sum    = (WAVE_BITS+2)'(x) + (WAVE_BITS+2)'(err) + (WAVE_BITS+2)'(lfsr_value[Q-1:0]);
    sum_hi = sum[WAVE_BITS+1:Q];
    if (sum_hi > (PWM_BITS+2)'(FRAME_LEN)) begin
      duty_next = FRAME_LEN;
      err_next  = '0;
    end else begin
      duty_next = sum_hi[PWM_BITS:0];
      err_next  = sum[Q-1:0];
    end
  end
`else
  logic [WAVE_BITS:0] sum;

  always_comb begin
    sum       = (WAVE_BITS+1)'(x) + (WAVE_BITS+1)'(err);
    duty_next = sum[WAVE_BITS:Q];
    err_next  = sum[Q-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      duty        <= (PWM_BITS+1)'(midscale(PWM_BITS));
      err         <= '0;
      held        <= WAVE_BITS'(midscale(WAVE_BITS));
      sample_buf  <= '0;
      pending     <= 1'b0;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      cnt         <= cnt + 1'b1;
      pwm_out     <= ({1'b0, cnt} < duty);
      frame_start <= (cnt == '0);
      overrun     <= sample_valid & !sample_ready;

      // Accept only when empty and consume only when full, so the two never collide.
      if (sample_valid && sample_ready) begin
        sample_buf <= conv;
        pending    <= 1'b1;
      end else if (boundary && pending) begin
        pending <= 1'b0;
      end

      if (boundary) begin
        duty <= duty_next;
        err  <= err_next;
        if (pending) held <= sample_buf;
      end
    end
  end

endmodule

// File: tb/tb_synth_pwm_dac.sv
// Scoreboard bench for synth_pwm_dac: expected per-frame duty queued by stimulus, checked by a frame monitor.
module tb_synth_pwm_dac;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic       sample_ready, pwm_out, frame_start, overrun;

  int checks = 0;
  int failures = 0;
  int ovr_cnt = 0;
  int exp_q[$];

  typedef struct {
    bit         send;
    bit         at_bnd;
    bit         dbl;
    logic [7:0] s;
    int         exp;
  } vec_t;

  vec_t tbl[$];

  synth_pwm_dac #(.WAVE_BITS(8), .PWM_BITS(5), .SIGNED_IN(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .frame_start  (frame_start),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 40);
    if (!frame_start) begin
      checks++;
      failures++;
      $display("FAIL frame_wait actual=timeout required=frame_start within 40 cycles");
    end
  endtask

  // Monitor: capture each 32-cycle output frame and compare against the queued duty.
  initial begin
    bit   active = 0;
    int   pos = 0;
    int   d;
    logic [31:0] pv, fv, ev;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 0;
        continue;
      end
      if (overrun === 1'b1) ovr_cnt++;
      if (!active && frame_start) begin
        active = 1;
        pos = 0;
      end
      if (active) begin
        pv[pos] = pwm_out;
        fv[pos] = frame_start;
        pos++;
        if (pos == 32) begin
          pos = 0;
          if (exp_q.size() > 0) begin
            d = exp_q.pop_front();
            for (int i = 0; i < 32; i++) ev[i] = (i < d);
            checks++;
            if (pv !== ev || fv !== 32'h1) begin
              failures++;
              $display("FAIL frame_duty actual pwm=%h fs=%h required pwm=%h fs=00000001 (duty %0d)",
                       pv, fv, ev, d);
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    tbl.push_back('{0, 0, 0, 8'h00, 16});
    tbl.push_back('{0, 0, 0, 8'h00, 16});
    tbl.push_back('{1, 0, 0, 8'h00, 16});
    tbl.push_back('{0, 0, 0, 8'h00, 16});
    tbl.push_back('{1, 0, 0, 8'h80, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 0});
    tbl.push_back('{1, 0, 0, 8'h7F, 31});
    tbl.push_back('{0, 0, 0, 8'h00, 32});
    tbl.push_back('{0, 0, 0, 8'h00, 32});
    tbl.push_back('{0, 0, 0, 8'h00, 32});
    tbl.push_back('{1, 0, 0, 8'h04, 17});
    tbl.push_back('{0, 0, 0, 8'h00, 16});
    tbl.push_back('{0, 0, 0, 8'h00, 17});
    tbl.push_back('{0, 0, 0, 8'h00, 16});
    tbl.push_back('{1, 0, 1, 8'h10, 18});
    tbl.push_back('{0, 0, 0, 8'h00, 18});
    tbl.push_back('{0, 0, 0, 8'h00, 18});
    tbl.push_back('{1, 1, 0, 8'h80, 18});
    tbl.push_back('{0, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 0});

    repeat (3) @(negedge clk);
    check_bit("reset_ready", sample_ready, 1'b1);
    check_bit("reset_pwm", pwm_out, 1'b0);
    check_bit("reset_frame_start", frame_start, 1'b0);
    check_bit("reset_overrun", overrun, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(16);

    foreach (tbl[f]) begin
      wait_frame();
      exp_q.push_back(tbl[f].exp);
      if (tbl[f].send) begin
        if (tbl[f].at_bnd) repeat (30) @(negedge clk);
        sample_in = tbl[f].s;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        if (tbl[f].dbl) begin
          check_bit("second_sees_ready_low", sample_ready, 1'b0);
          @(negedge clk);
          sample_in = 8'h20;
          sample_valid = 1'b1;
          @(negedge clk);
          sample_valid = 1'b0;
          check_bit("overrun_pulse", overrun, 1'b1);
          @(negedge clk);
          check_bit("overrun_one_cycle", overrun, 1'b0);
        end
      end
    end

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d frames pending required=0", exp_q.size());
    end
    checks++;
    if (ovr_cnt != 1) begin
      failures++;
      $display("FAIL overrun_total actual=%0d required=1", ovr_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/synth_pwm_dac.md
# synth_pwm_dac

Output stage of the synth voice. Consumes each signed filter output sample (the voice's `y` word, `WAVE_BITS` wide) and drives one audio pin with a PWM waveform. It requantises `WAVE_BITS` to `PWM_BITS` with first-order error feedback (noise shaping), holds the last sample when no new one arrives, and flags dropped samples.

## Interface
Parameters:
- `WAVE_BITS`, default 8: input sample width.
- `PWM_BITS`, default 5: PWM frame is 2^PWM_BITS cycles. Must be less than `WAVE_BITS`. Let Q = WAVE_BITS-PWM_BITS.
- `SIGNED_IN`, default 1: 1 means the sample is two's complement and is converted to offset binary by inverting its MSB. 0 means the sample is unsigned.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `sample_in`, in, WAVE_BITS: sample data.
- `sample_valid`, in, 1: sample offered this cycle.
- `sample_ready`, out, 1: buffer empty. Combinational, equal to !pending.
- `pwm_out`, out, 1: registered PWM output.
- `frame_start`, out, 1: registered. High during the cycle in which `pwm_out` shows frame position 0.
- `overrun`, out, 1: registered one-cycle pulse when a sample is dropped.

## Operation
- Input buffer holds one entry: `buf` plus a `pending` flag.
  - When `sample_valid & sample_ready`: `buf` ← converted sample, `pending` ← 1.
  - When `sample_valid & !sample_ready`: the sample is discarded and `overrun` pulses the next cycle.
- Frame counter `cnt`, PWM_BITS wide: increments every cycle and wraps from 2^PWM_BITS−1 to 0.
- Frame boundary is the cycle with `cnt` == 2^PWM_BITS−1. At the boundary:
  - Source x = `buf` if `pending`, else `held`.
  - If `pending`: `held` ← `buf` and `pending` ← 0.
  - sum = x + err, computed WAVE_BITS+1 bits wide.
  - duty ← sum >> Q. Duty is PWM_BITS+1 bits wide, range 0..2^PWM_BITS.
  - err ← sum[Q−1:0].
- No bypass: a sample accepted in the boundary cycle is used one frame later.
- Per-cycle output: `pwm_out` at t+1 = (`cnt`(t) < duty(t)).
  - duty 0 gives all-low.
  - duty 2^PWM_BITS gives all-high.
- `frame_start` at t+1 = (`cnt`(t) == 0).
- Reset values:
  - `cnt` = 0
  - duty = 2^(PWM_BITS−1)
  - err = 0
  - `held` = 2^(WAVE_BITS−1) (silence)
  - `pending` = 0, so `sample_ready` = 1
  - `pwm_out` = 0, `frame_start` = 0, `overrun` = 0
- Reset mid-frame discards `buf`, err and duty. The first frame after reset starts at `cnt` 0.

## Timing
- Latency from sample acceptance to first use:
  - Accepted in a non-boundary cycle: used at the next boundary, and appears in `pwm_out` from the following frame position 0.
  - Accepted in the boundary cycle: one frame later than that.
- The upstream voice produces one sample per 4 cycles. With the default PWM_BITS = 5 (32-cycle frame), most samples are dropped by design. `overrun` is informational only.
- All state updates happen on rising `clk`. There are no combinational paths from inputs to `pwm_out`, `frame_start` or `overrun`.

## Configuration
Macro: `SYNTH_PWM_DITHER_EN`.
- Defined:
  - A 16-bit Galois LFSR (taps 16, 14, 13, 11; seed 0xACE1 on reset) advances once per frame boundary.
  - Its low Q bits are added into sum, so sum is WAVE_BITS+2 bits wide.
  - If sum >> Q exceeds 2^PWM_BITS: duty is clamped to 2^PWM_BITS and err ← 0.
- Undefined: no LFSR logic is present, and behaviour is exactly as in Operation.

## Structure
- Shared package `synth_pkg` holds:
  - the default WAVE_BITS;
  - LFSR seed and tap constants;
  - a midscale helper function (2^(n−1)).
- Submodule `synth_lfsr16`: 16-bit Galois LFSR with `clk`, `reset`, `step` inputs and a `value` output. It is instantiated only under `SYNTH_PWM_DITHER_EN` and is reusable by a later noise oscillator.

## Test plan
All scenarios use WAVE_BITS = 8, PWM_BITS = 5, SIGNED_IN = 1, dither undefined.
1. Reset, no samples → `sample_ready` = 1, `pwm_out` = 0 during reset; every frame then has 16 high cycles followed by 16 low, and `frame_start` pulses every 32 cycles.
2. Sample 0x00 → x = 128; duty 16 every frame; err stays 0.
3. Sample 0x80 → x = 0; duty 0, so `pwm_out` is constantly low from the next frame.
4. Sample 0x7F held for several frames → x = 255; duty sequence 31, 32, 32, … (err runs 7, 6, 5, …); mean duty matches 255/8 within 1/32 of a frame.
5. Sample 0x04 held for several frames → x = 132; duty alternates 16, 17, 16, 17 (err alternates 4, 0).
6. Two `sample_valid` pulses within one frame (0x10 then 0x20) → the second sees `sample_ready` = 0; `overrun` is high for exactly one cycle; the next duty is computed from 0x10 (x = 144, duty 18).
